// File: rtl/lsu_pkg.sv
// lsu_pkg: access size encodings, LSU state enum and alignment helper.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, LD_DATA, WR} state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    assign sh = {offset, 3'b000};

    always_comb begin
        lane    = ld_word >> sh;
        ld_data = size == SZ_BYTE ? {{24{is_signed & lane[7]}}, lane[7:0]} :
                  size == SZ_HALF ? {{16{is_signed & lane[15]}}, lane[15:0]} : ld_word;
        mask    = (size == SZ_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        st_word = (old_word & ~mask) | ((new_data << sh) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU driving a registered-read word memory port.
// Optional LSU_RANGE_CHECK_EN rejects word indices >= MEM_DEPTH as illegal.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_t      state, state_n;
    logic [1:0]  off_q, size_q;
    logic        signed_q, we_q, err_pend;
    logic        accept, illegal;
    logic [31:0] word_idx, ld_data, st_word;

    assign word_idx     = {2'b00, req_addr[31:2]};
    assign req_ready    = state == IDLE;
    assign accept       = req_valid && req_ready;
    assign illegal      = req_size == 2'b11 || misaligned(req_size, req_addr[1:0]) ||
                          (RANGE_CHECK && word_idx >= 32'(MEM_DEPTH));
    assign mem_memread  = state == RD;
    assign mem_memwrite = state == WR;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept && !illegal ? (req_we && req_size == SZ_WORD ? WR : RD) : IDLE;
            RD:      state_n = LD_DATA;
            LD_DATA: state_n = we_q ? WR : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // mem_write_data holds the store data until LD_DATA replaces it with the merged word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q          <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            we_q           <= 1'b0;
            err_pend       <= 1'b0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            err_pend   <= accept && illegal;
            resp_valid <= err_pend || state == WR || (state == LD_DATA && !we_q);
            resp_err   <= err_pend;
            resp_rdata <= state == LD_DATA && !we_q ? ld_data : 32'h0;
            if (accept) begin
                off_q          <= req_addr[1:0];
                size_q         <= req_size;
                signed_q       <= req_signed;
                we_q           <= req_we;
                mem_read_addr  <= word_idx;
                mem_write_addr <= word_idx;
                mem_write_data <= req_wdata;
            end
            if (state == LD_DATA && we_q) mem_write_data <= st_word;
        end
    end

    lsu_lane_align u_align (
        .ld_word  (mem_read_data),
        .offset   (off_q),
        .size     (size_q),
        .is_signed(signed_q),
        .old_word (mem_read_data),
        .new_data (mem_write_data),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-level reference model of the LSU.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data;
    logic        mem_memwrite, mem_memread;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_read_data(mem_read_data)
    );

    logic [31:0] tmem    [0:1023];
    logic [31:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (mem_memwrite) tmem[mem_write_addr[9:0]] <= mem_write_data;
        if (mem_memread)  mem_read_data <= tmem[mem_read_addr[9:0]];
    end

    typedef struct {logic [31:0] rdata; logic err; int due;} resp_t;
    typedef struct {bit wr; logic [31:0] idx; logic [31:0] data;} strb_t;
    resp_t rq[$];
    strb_t sq[$];
    int total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_byte(input logic [31:0] w, input int k);
        return (w >> (8 * k)) & 32'hFF;
    endfunction

    function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
        bit r;
        r = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
`ifdef LSU_RANGE_CHECK_EN
        r = r || (a / 4 >= 256);
`endif
        return r;
    endfunction

    task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int n, off, idx, c0, b;
        longint v;
        logic [31:0] old, nw;
        n   = 1 << sz;
        off = a % 4;
        idx = (a / 4) % 1024;
        old = ref_mem[idx];
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        b = 0;
        while (!req_ready && b < 20) begin @(negedge clk); b++; end
        if (!req_ready) begin
            bad++; total++;
            $display("FAIL req_ready_timeout: got 0 want 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        req_valid = 1'b0;
        if (is_illegal(sz, a)) begin
            rq.push_back('{32'h0, 1'b1, c0 + 1});
        end else if (we) begin
            nw = old;
            for (int i = 0; i < n; i++)
                nw = (nw & ~(32'hFF << (8 * (off + i)))) | (get_byte(wd, i) << (8 * (off + i)));
            ref_mem[idx] = nw;
            if (n == 4) begin
                sq.push_back('{1'b1, 32'(idx), nw});
                rq.push_back('{32'h0, 1'b0, c0 + 1});
            end else begin
                sq.push_back('{1'b0, 32'(idx), 32'h0});
                sq.push_back('{1'b1, 32'(idx), nw});
                rq.push_back('{32'h0, 1'b0, c0 + 3});
            end
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(get_byte(old, off + i)) << (8 * i));
            if (sg && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
            sq.push_back('{1'b0, 32'(idx), 32'h0});
            rq.push_back('{v[31:0], 1'b0, c0 + 2});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_err && !resp_valid) chk("err_without_valid", 32'(resp_err), 32'h0);
            if (mem_memread && mem_memwrite) chk("both_strobes", 32'(mem_memwrite), 32'h0);
            if (req_ready && (mem_memread || mem_memwrite))
                chk("strobe_in_idle", 32'(mem_memread | mem_memwrite), 32'h0);
            if (mem_memread || mem_memwrite) begin
                if (sq.size() == 0) begin
                    chk("unexpected_strobe", {mem_memwrite, mem_memread}, 32'h0);
                end else begin
                    strb_t s;
                    s = sq.pop_front();
                    chk("strobe_kind", 32'(mem_memwrite), 32'(s.wr));
                    chk(s.wr ? "write_addr" : "read_addr", s.wr ? mem_write_addr : mem_read_addr, s.idx);
                    if (s.wr) chk("write_data", mem_write_data, s.data);
                end
            end
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_err", 32'(resp_err), 32'(r.err));
                    chk("resp_cycle", 32'(cyc), 32'(r.due));
                end
            end
        end
    end

    initial begin
        int b, mism;
        for (int i = 0; i < 1024; i++) begin
            tmem[i] = $urandom;
            ref_mem[i] = tmem[i];
        end
        tmem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'h1);
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        chk("reset_strobes", {mem_memwrite, mem_memread}, 32'h0);
        chk("reset_read_addr", mem_read_addr, 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;

        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h17, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h14, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_1234);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h15, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h14, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h16, 32'hDEAD_BEEF);

        repeat (4) @(posedge clk);
        tmem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h14; req_wdata = 32'h55;
        b = 0;
        while (!req_ready && b < 20) begin @(negedge clk); b++; end
        @(posedge clk); #1 req_valid = 1'b0;
        sq.push_back('{1'b0, 32'd5, 32'h0});
        @(posedge clk); #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_memwrite", 32'(mem_memwrite), 32'h0);
            chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 32'h1);
        chk("post_reset_sq", 32'(sq.size()), 32'h0);
        chk("word5_intact", tmem[5], 32'h8899AABB);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);

        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 2047)) :
                32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        b = 0;
        while ((rq.size() != 0 || sq.size() != 0) && b < 20) begin @(posedge clk); b++; end
        @(negedge clk);
        chk("resp_queue_drained", 32'(rq.size()), 32'h0);
        chk("strobe_queue_drained", 32'(sq.size()), 32'h0);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (tmem[i] !== ref_mem[i]) mism++;
        chk("memory_image", 32'(mism), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage initiator that drives the word-addressed, registered-read data memory port (memread/memwrite, separate read/write addresses, one-cycle read latency, write-over-read priority). Accepts byte/half/word load and store requests from the pipeline and converts byte addresses to word indices. Performs sign/zero extension and read-modify-write for sub-word stores. Returns one response per request, with an error flag for illegal accesses.

Parameters:
MEM_DEPTH, 256, number of 32-bit words in the attached data memory; used only by the optional range check.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready at a clk edge
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  load sign-extend (1) / zero-extend (0); ignored for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  qualifies resp_valid; illegal/misaligned access
mem_read_addr  out  32  word index to memory
mem_write_addr  out  32  word index to memory
mem_write_data  out  32  full word to memory
mem_memwrite  out  1  memory write strobe
mem_memread  out  1  memory read strobe
mem_read_data  in  32  memory registered read data

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. Reset forces state IDLE, all registered outputs 0, and drops any in-flight request with no response and no write.
- Word index = {2'b00, req_addr[31:2]}. Lanes are little-endian: byte offset 0 occupies bits [7:0]. A half at offset 2 occupies [31:16].
- States:
  - IDLE: req_ready=1. This is the only state with req_ready=1.
  - RD: mem_memread=1 for exactly this cycle.
  - LD_DATA: mem_read_data is valid in this cycle.
  - WR: mem_memwrite=1 for exactly this cycle.
- mem_memread and mem_memwrite are never both 1. Both are 0 in IDLE.
- mem_read_addr and mem_write_addr are registered at accept and hold between requests.
- Illegal request: size 11, half with addr[0]=1, or word with addr[1:0]≠0.
  - Stay in IDLE; no memory strobe.
  - On the next edge: resp_valid=1, resp_err=1, resp_rdata=0.
- Load (legal), accepted at edge E0: IDLE→RD→LD_DATA.
  - At E2, resp_rdata = extracted lane extended per req_signed (word loads pass through unchanged), resp_valid=1, state returns to IDLE.
  - Response visible 2 cycles after accept; next accept possible at E3.
- Store word: IDLE→WR with mem_write_data=req_wdata. At E1 the memory writes and resp_valid=1 (resp_rdata=0); state returns to IDLE.
- Store byte/half (read-modify-write): IDLE→RD→LD_DATA.
  - At E2, the write-data register takes mem_read_data with the target lane replaced by req_wdata[7:0] or [15:0]; state goes to WR.
  - At E3 the memory writes and resp_valid=1.
  - Untouched lanes must equal the prior memory contents.
- resp_valid is high exactly one cycle per accepted request. resp_err=0 whenever resp_valid=0.
- req_valid while busy is ignored; the requester holds the request until it is accepted.

Optional Feature:
LSU_RANGE_CHECK_EN
- Defined: a request whose word index ≥ MEM_DEPTH is treated as illegal (no strobe, err response after 1 cycle).
- Undefined: no range check; the word index is issued to memory unmodified.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum IDLE/RD/LD_DATA/WR
  - function computing the misaligned flag
- Sub-module lsu_lane_align, purely combinational, providing:
  - load extract + extend: inputs word, offset, size, signed
  - store merge: inputs old word, new data, offset, size
- The FSM, request/response registers and memory port stay in load_store_unit.

Test Plan:
All scenarios preload word 5 (byte 0x14) = 32'h8899AABB.
1. Load word at 0x14 → mem_read_addr=5; memread high exactly 1 cycle; resp_valid 2 cycles after accept; resp_rdata=8899AABB; resp_err=0.
2. Load byte at 0x17, signed → FFFFFF88; same access unsigned → 00000088; signed half at 0x14 → FFFFAABB.
3. Store half at 0x16, wdata=0x00001234 → one memread then one memwrite; mem_write_addr=5; mem_write_data=1234AABB; resp 3 cycles after accept; a following word load returns 1234AABB.
4. Load word at 0x15, and separately size=11 → resp_err=1, resp_rdata=0 one cycle after accept; no memread/memwrite ever asserted.
5. Store byte at 0x14; drop rst_n during LD_DATA → memwrite never asserts; resp_valid=0; after release req_ready=1; word 5 still 8899AABB.
6. Load word at 0x400 (index 256): with LSU_RANGE_CHECK_EN → resp_err=1, no strobe; without it → memread with mem_read_addr=256.
